keypad_debounce: RTL and testbench
==================================

KEYPAD_DEBOUNCE -- requirements
Module: keypad_debounce

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 4, meaning consecutive stable synchronized samples needed to accept a press or a release (legal range 2..255).
REQ-002 The block SHALL have parameter CNT_W, default 8, meaning debounce counter width; DEBOUNCE_CYCLES SHALL fit in CNT_W bits.
REQ-003 clock  input  1  system clock; all state is updated on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low; clears all state immediately.
REQ-005 key_raw  input  10  raw digit buttons 0..9, active-high, asynchronous to clock, may bounce.
REQ-006 enter_raw  input  1  raw enter button, active-high, asynchronous, may bounce.
REQ-007 num  output  10  one-hot code of the last accepted digit, held until the next accepted digit; feeds the downstream lock FSM.
REQ-008 x  output  1  one-cycle pulse on each accepted enter press.
REQ-009 key_valid  output  1  one-cycle pulse in the cycle num takes a new value.
REQ-010 err  output  1  one-cycle pulse on an accepted multi-key press (only with KEYPAD_MULTIKEY_ERR_EN); tied 0 otherwise.

Function
REQ-011 The block SHALL pass {enter_raw, key_raw} through a 2-flop synchronizer, producing the 11-bit vector kv; all decisions use kv only.
REQ-012 The FSM SHALL have states IDLE, PRESS_DB, ACCEPT, HELD, RELEASE_DB, encoded in 3 bits.
REQ-013 IDLE: kv non-zero -> capture kv as candidate, clear counter, go PRESS_DB; else stay.
REQ-014 PRESS_DB: kv == 0 -> IDLE; kv != candidate -> recapture candidate, clear counter; kv == candidate -> increment counter; when count reaches DEBOUNCE_CYCLES-1 -> ACCEPT.
REQ-015 ACCEPT (one cycle): single-hot digit candidate -> num <= candidate[9:0], key_valid = 1; candidate == enter only -> x = 1, num unchanged; multi-hot candidate -> handled per REQ-024/025; always -> HELD.
REQ-016 HELD: kv == 0 -> clear counter, go RELEASE_DB; any non-zero kv, including a different key, is ignored (no rollover).
REQ-017 RELEASE_DB: kv != 0 -> HELD; kv == 0 -> increment; when count reaches DEBOUNCE_CYCLES-1 -> IDLE.
REQ-018 Latency: with raw input stable from rising edge k, the pulse (x, key_valid or err) SHALL be high in the cycle following edge k+DEBOUNCE_CYCLES+2.
REQ-019 At most one of x, key_valid, err SHALL be high in any cycle; each pulse lasts exactly one cycle per accepted press.
REQ-020 A press held indefinitely SHALL produce exactly one pulse; a new pulse requires a debounced release first.
REQ-021 Any kv change within PRESS_DB SHALL restart the count; a glitch shorter than DEBOUNCE_CYCLES samples produces no output.
REQ-022 Counter SHALL never wrap; it is cleared on every state entry.

Reset
REQ-023 On reset low: state IDLE, synchronizer, candidate, counter cleared; num = 10'b0, x = 0, key_valid = 0, err = 0; reset mid-debounce or mid-hold discards the press.

Configuration
REQ-024 With KEYPAD_MULTIKEY_ERR_EN defined, an accepted multi-hot candidate SHALL pulse err for one cycle, leave num unchanged, and not pulse x or key_valid.
REQ-025 Without KEYPAD_MULTIKEY_ERR_EN, err SHALL be constant 0 and an accepted multi-hot candidate SHALL be silently discarded (still going to HELD).

Structure
REQ-026 State encodings, key width (10), vector width (11) and enter bit index (10) SHALL reside in shared package doorlock_pkg.
REQ-027 The 2-flop synchronizer SHALL be a separate sub-module sync_2ff, parameterized by width.

Verification (DEBOUNCE_CYCLES = 4)
REQ-028 Clean press key_raw = 10'b00_0010_0000 held 20 cycles -> key_valid pulse 6 edges after first sample, num = 10'b00_0010_0000 and holds after release.
REQ-029 Bouncing key 3 (toggle every 2 cycles for 10 cycles, then stable) -> exactly one key_valid, num = 10'b00_0000_1000.
REQ-030 enter_raw held 8 cycles -> single x pulse, num unchanged, key_valid 0.
REQ-031 Keys 1 and 9 together stable 10 cycles -> err pulse with macro, no pulse without; num unchanged in both builds.
REQ-032 Key 9 held, key 2 added then key 9 released -> no new pulse until all keys are released for 4 cycles.
REQ-033 reset low during PRESS_DB of key 5 -> all outputs 0, no pulse after reset deasserts while key remains held until it re-debounces from IDLE (pulse 6 edges after reset release).

Source files
------------

// File: rtl/doorlock_pkg.sv
// Shared definitions for the door-lock keypad front end: key/vector widths,
// the enter bit position, debounce FSM state encoding and a helper that
// classifies a captured key vector.
package doorlock_pkg;

  localparam int KEY_W     = 10;  // digit buttons 0..9
  localparam int VEC_W     = 11;  // {enter, digits}
  localparam int ENTER_IDX = 10;  // enter bit inside the vector

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_PRESS_DB   = 3'd1,
    ST_ACCEPT     = 3'd2,
    ST_HELD       = 3'd3,
    ST_RELEASE_DB = 3'd4
  } kd_state_e;

  typedef enum logic [1:0] {
    CAND_NONE  = 2'd0,
    CAND_DIGIT = 2'd1,
    CAND_ENTER = 2'd2,
    CAND_MULTI = 2'd3
  } cand_kind_e;

  // Single digit, enter alone, several buttons at once, or nothing.
  function automatic cand_kind_e classify(input logic [VEC_W-1:0] v);
    int unsigned ones;
    ones = 0;
    for (int i = 0; i < VEC_W; i++) begin
      ones = ones + {31'd0, v[i]};
    end
    if (ones == 0) begin
      return CAND_NONE;
    end else if (ones > 1) begin
      return CAND_MULTI;
    end else if (v[ENTER_IDX]) begin
      return CAND_ENTER;
    end else begin
      return CAND_DIGIT;
    end
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous button inputs, one pair of flops
// per bit, cleared by the asynchronous active-low reset.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two-stage resampling into the clock domain.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_debounce.sv
// Keypad debouncer: synchronizes ten digit buttons plus enter, debounces a
// press and its release, and reports each accepted press exactly once
// (key_valid for a digit, x for enter). Holding keys never repeats and a
// second key pressed during a hold is ignored.
// Optional feature macro KEYPAD_MULTIKEY_ERR_EN: when defined, an accepted
// multi-key press pulses err; otherwise such a press is silently dropped
// and err is tied low.
module keypad_debounce
  import doorlock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [KEY_W-1:0] key_raw,
  input  logic             enter_raw,
  output logic [KEY_W-1:0] num,
  output logic             x,
  output logic             key_valid,
  output logic             err
);

  // Last count value of a debounce window; reaching it with the input still
  // stable completes the window, so the counter never needs to wrap.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [VEC_W-1:0] kv;

  kd_state_e        state_q, state_d;
  logic [VEC_W-1:0] cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [KEY_W-1:0] num_q, num_d;
  logic             x_q, x_d;
  logic             key_valid_q, key_valid_d;
`ifdef KEYPAD_MULTIKEY_ERR_EN
  logic             err_q, err_d;
`endif

  sync_2ff #(
    .WIDTH (VEC_W)
  ) u_sync (
    .clock (clock),
    .reset (reset),
    .d_i   ({enter_raw, key_raw}),
    .q_o   (kv)
  );

  // State, candidate, counter and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cand_q      <= '0;
      cnt_q       <= '0;
      num_q       <= '0;
      x_q         <= 1'b0;
      key_valid_q <= 1'b0;
`ifdef KEYPAD_MULTIKEY_ERR_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      num_q       <= num_d;
      x_q         <= x_d;
      key_valid_q <= key_valid_d;
`ifdef KEYPAD_MULTIKEY_ERR_EN
      err_q       <= err_d;
`endif
    end
  end

  // Debounce FSM. The pulse registers are loaded on the edge that enters
  // ACCEPT, so the pulse is high for exactly the one ACCEPT cycle and num
  // changes in that same cycle.
  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    num_d       = num_q;
    x_d         = 1'b0;
    key_valid_d = 1'b0;
`ifdef KEYPAD_MULTIKEY_ERR_EN
    err_d       = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (kv != '0) begin
          cand_d  = kv;
          cnt_d   = '0;
          state_d = ST_PRESS_DB;
        end
      end
      ST_PRESS_DB: begin
        if (kv == '0) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (kv != cand_q) begin
          // Bounce or a changed combination: restart on the new value.
          cand_d = kv;
          cnt_d  = '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_ACCEPT;
          case (classify(cand_q))
            CAND_DIGIT: begin
              num_d       = cand_q[KEY_W-1:0];
              key_valid_d = 1'b1;
            end
            CAND_ENTER: begin
              x_d = 1'b1;
            end
            CAND_MULTI: begin
`ifdef KEYPAD_MULTIKEY_ERR_EN
              err_d = 1'b1;
`endif
            end
            default: ;
          endcase
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_ACCEPT: begin
        cnt_d   = '0;
        state_d = ST_HELD;
      end
      ST_HELD: begin
        if (kv == '0) begin
          cnt_d   = '0;
          state_d = ST_RELEASE_DB;
        end
      end
      ST_RELEASE_DB: begin
        if (kv != '0) begin
          cnt_d   = '0;
          state_d = ST_HELD;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign num       = num_q;
  assign x         = x_q;
  assign key_valid = key_valid_q;
`ifdef KEYPAD_MULTIKEY_ERR_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_debounce.sv
// Bench for keypad_debounce (DEBOUNCE_CYCLES = 4). The reference model works
// on runs of synchronized samples: a press is accepted once the same
// non-zero vector has been seen D+1 samples in a row while armed; after an
// acceptance one sample is skipped and D+1 consecutive zero samples re-arm.
module tb_keypad_debounce;
  import doorlock_pkg::*;

  localparam int D = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic [9:0] key_raw;
  logic       enter_raw;
  logic [9:0] num;
  logic       x;
  logic       key_valid;
  logic       err;

  int vectors     = 0;
  int miscompares = 0;

  // model state
  logic [10:0] pipe1, pipe2;
  bit          armed;
  int          run;
  logic [10:0] last;
  bit          skip;
  int          zrun;
  logic [9:0]  exp_num;
  logic        exp_x, exp_kv, exp_err;

  // per-scenario bookkeeping
  int step_no;
  int first_pulse;
  int n_kv, n_x, n_err;

  keypad_debounce #(
    .DEBOUNCE_CYCLES (D),
    .CNT_W           (8)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .key_raw   (key_raw),
    .enter_raw (enter_raw),
    .num       (num),
    .x         (x),
    .key_valid (key_valid),
    .err       (err)
  );

  always #5 clock = ~clock;

  task automatic model_reset();
    pipe1 = '0; pipe2 = '0;
    armed = 1'b1; run = 0; last = '0; skip = 1'b0; zrun = 0;
    exp_num = '0; exp_x = 1'b0; exp_kv = 1'b0; exp_err = 1'b0;
  endtask

  // One rising edge of the model with raw vector v present at that edge.
  task automatic model_edge(input logic [10:0] v);
    logic [10:0] kvs;
    kvs   = pipe2;
    pipe2 = pipe1;
    pipe1 = v;
    exp_x = 1'b0; exp_kv = 1'b0; exp_err = 1'b0;
    if (armed) begin
      if (kvs == '0) begin
        run = 0;
      end else if (run > 0 && kvs == last) begin
        run++;
      end else begin
        last = kvs;
        run  = 1;
      end
      if (run == D + 1) begin
        if ($countones(kvs) > 1) begin
`ifdef KEYPAD_MULTIKEY_ERR_EN
          exp_err = 1'b1;
`endif
        end else if (kvs[10]) begin
          exp_x = 1'b1;
        end else begin
          exp_kv  = 1'b1;
          exp_num = kvs[9:0];
        end
        armed = 1'b0; skip = 1'b1; zrun = 0;
      end
    end else if (skip) begin
      skip = 1'b0;
    end else if (kvs == '0) begin
      zrun++;
      if (zrun == D + 1) begin
        armed = 1'b1;
        run   = 0;
      end
    end else begin
      zrun = 0;
    end
  endtask

  task automatic check_outputs(input string tag);
    vectors++;
    assert (num === exp_num) else begin
      miscompares++;
      $error("FAIL %s num: observed %b expected %b", tag, num, exp_num);
    end
    vectors++;
    assert (key_valid === exp_kv) else begin
      miscompares++;
      $error("FAIL %s key_valid: observed %b expected %b", tag, key_valid, exp_kv);
    end
    vectors++;
    assert (x === exp_x) else begin
      miscompares++;
      $error("FAIL %s x: observed %b expected %b", tag, x, exp_x);
    end
    vectors++;
    assert (err === exp_err) else begin
      miscompares++;
      $error("FAIL %s err: observed %b expected %b", tag, err, exp_err);
    end
  endtask

  task automatic begin_scn();
    step_no = 0; first_pulse = -1; n_kv = 0; n_x = 0; n_err = 0;
  endtask

  // Apply v across one rising edge and check the outputs 1 time unit later.
  task automatic step(input logic [10:0] v, input string tag);
    key_raw   = v[9:0];
    enter_raw = v[10];
    @(posedge clock);
    model_edge(v);
    #1;
    check_outputs(tag);
    if ((key_valid || x || err) && first_pulse < 0) first_pulse = step_no;
    n_kv  += int'(key_valid);
    n_x   += int'(x);
    n_err += int'(err);
    step_no++;
    $display("step %s raw=%b num=%b kv=%b x=%b err=%b", tag, v, num, key_valid, x, err);
  endtask

  task automatic hold(input logic [10:0] v, input int n, input string tag);
    for (int i = 0; i < n; i++) step(v, tag);
  endtask

  task automatic expect_int(input int obs, input int req, input string tag);
    vectors++;
    assert (obs == req) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, req);
    end
  endtask

  // Assert reset between edges, keep it for two edges, check that every
  // output cleared, release it between edges.
  task automatic pulse_reset(input string tag);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_outputs(tag);
    repeat (2) @(posedge clock);
    #2;
    check_outputs(tag);
    reset = 1'b1;
  endtask

  localparam logic [10:0] K5    = 11'b000_0010_0000;
  localparam logic [10:0] K3    = 11'b000_0000_1000;
  localparam logic [10:0] ENT   = 11'b100_0000_0000;
  localparam logic [10:0] K1K9  = 11'b010_0000_0010;
  localparam logic [10:0] K9    = 11'b010_0000_0000;
  localparam logic [10:0] K2    = 11'b000_0000_0100;
  localparam logic [10:0] K9K2  = 11'b010_0000_0100;
  localparam logic [10:0] NONE  = 11'b000_0000_0000;

  initial begin
    logic [10:0] v;
    int          pick;
    key_raw   = '0;
    enter_raw = 1'b0;
    reset     = 1'b0;
    model_reset();
    #3;
    check_outputs("reset");
    repeat (3) @(posedge clock);
    #2;
    reset = 1'b1;
    hold(NONE, 3, "idle");

    // Clean press of key 5, latency and hold after release.
    begin_scn();
    hold(K5, 20, "clean");
    hold(NONE, 10, "clean_rel");
    expect_int(first_pulse, D + 2, "clean_latency");
    expect_int(n_kv, 1, "clean_kv_count");
    expect_int(int'(num), int'(K5[9:0]), "clean_num_held");

    // Bouncing key 3.
    begin_scn();
    for (int i = 0; i < 5; i++) begin
      hold((i % 2 == 0) ? K3 : NONE, 2, "bounce");
    end
    hold(K3, 12, "bounce_stable");
    hold(NONE, 8, "bounce_rel");
    expect_int(n_kv, 1, "bounce_kv_count");
    expect_int(int'(num), int'(K3[9:0]), "bounce_num");

    // Enter alone.
    begin_scn();
    hold(ENT, 8, "enter");
    hold(NONE, 8, "enter_rel");
    expect_int(n_x, 1, "enter_x_count");
    expect_int(n_kv, 0, "enter_kv_count");
    expect_int(int'(num), int'(K3[9:0]), "enter_num");

    // Keys 1 and 9 together.
    begin_scn();
    hold(K1K9, 10, "multi");
    hold(NONE, 8, "multi_rel");
`ifdef KEYPAD_MULTIKEY_ERR_EN
    expect_int(n_err, 1, "multi_err_count");
`else
    expect_int(n_err, 0, "multi_err_count");
`endif
    expect_int(n_kv + n_x, 0, "multi_other_pulses");
    expect_int(int'(num), int'(K3[9:0]), "multi_num");

    // No rollover: key 9, add 2, drop 9, brief gap, key 2 again.
    begin_scn();
    hold(K9, 8, "roll");
    hold(K9K2, 4, "roll");
    hold(K2, 6, "roll");
    hold(NONE, 2, "roll");
    hold(K2, 8, "roll");
    hold(NONE, 8, "roll_rel");
    expect_int(n_kv, 1, "roll_kv_count");
    expect_int(int'(num), int'(K9[9:0]), "roll_num");

    // Reset during press debounce of key 5; re-debounce from IDLE.
    begin_scn();
    hold(K5, 3, "rst_mid");
    pulse_reset("rst_mid_reset");
    begin_scn();
    hold(K5, 12, "rst_after");
    hold(NONE, 8, "rst_after_rel");
    expect_int(first_pulse, D + 2, "rst_latency");
    expect_int(n_kv, 1, "rst_kv_count");

    // Randomized segments against the model.
    for (int s = 0; s < 250; s++) begin
      pick = $urandom_range(0, 9);
      if (pick <= 2) v = NONE;
      else if (pick <= 6) v = 11'(1) << $urandom_range(0, 9);
      else if (pick == 7) v = ENT;
      else if (pick == 8) v = (11'(1) << $urandom_range(0, 10)) | (11'(1) << $urandom_range(0, 10));
      else v = 11'($urandom_range(0, 2047));
      hold(v, $urandom_range(1, 10), "rand");
      if ($urandom_range(0, 39) == 0) pulse_reset("rand_reset");
    end
    hold(NONE, 8, "final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
